// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: slice width, stage-count helper and a
// width-legality check for the lookahead-based datapath blocks.
package arith_pkg;

    localparam int SLICE_W = 4;

    function automatic int num_stages(input int width, input int slices_per_stage);
        return width / (SLICE_W * slices_per_stage);
    endfunction

endpackage

// Expands to a generate-time error when W is not a positive multiple of M.
`ifndef ARITH_CHECK_WIDTH
`define ARITH_CHECK_WIDTH(W, M) \
    if ((M) <= 0 || (W) <= 0 || ((W) % (M)) != 0) begin : g_width_check \
        $error("operand width %0d is not a positive multiple of %0d", (W), (M)); \
    end
`endif

// File: rtl/cla_slice4.sv
// Combinational 4-bit lookahead-carry slice with group propagate/generate
// and the carry into bit 3 exposed for signed-overflow detection.
module cla_slice4
    import arith_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] s,
    output logic               gg,
    output logic               pg,
    output logic               c3
);

    logic [SLICE_W-1:0] g;
    logic [SLICE_W-1:0] p;
    logic               c1;
    logic               c2;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is a flat sum of products: no ripple inside the slice.
    assign c1 = g[0] | (p[0] & cin);
    assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

    assign s  = p ^ {c3, c2, c1, cin};
    assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    assign pg = &p;

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined add/subtract unit: each stage resolves SLICES_PER_STAGE lookahead
// slices and registers the carry; valid/ready handshake with collapsing bubbles.
module cla_pipe_adder
    import arith_pkg::*;
#(
    parameter int WIDTH            = 16,
    parameter int SLICES_PER_STAGE = 1
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf
);

    localparam int STAGE_W    = SLICE_W * SLICES_PER_STAGE;
    localparam int NUM_STAGES = num_stages(WIDTH, SLICES_PER_STAGE);

    `ARITH_CHECK_WIDTH(WIDTH, STAGE_W)

    logic [NUM_STAGES-1:0] vld;
    logic [NUM_STAGES-1:0] adv;

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        localparam int LO = k * STAGE_W;

        // word_q carries resolved sum bits below the slice boundary and
        // still-unresolved A bits above it; b_q holds the (possibly inverted) B.
        logic             vld_q;
        logic [WIDTH-1:0] word_q;
        logic [WIDTH-1:0] b_q;
        logic             cy_q;
        logic             ovf_q;

        logic             up_vld;
        logic [WIDTH-1:0] a_src;
        logic [WIDTH-1:0] b_src;
        logic             cin_stage;
        logic [STAGE_W-1:0] s_stage;
        logic [WIDTH-1:0] word_d;
        logic             cout;
        logic             c3_top;

        if (k == 0) begin : g_src
            assign up_vld    = in_valid;
            assign a_src     = a_in;
            assign b_src     = sub ? ~b_in : b_in;
            assign cin_stage = sub | c_in;
        end else begin : g_src
            assign up_vld    = g_stage[k-1].vld_q;
            assign a_src     = g_stage[k-1].word_q;
            assign b_src     = g_stage[k-1].b_q;
            assign cin_stage = g_stage[k-1].cy_q;
        end

        for (genvar j = 0; j < SLICES_PER_STAGE; j++) begin : g_slice
            localparam int BIT = LO + j * SLICE_W;

            logic               cin_s;
            logic               gg_s;
            logic               pg_s;
            logic               c3_s;
            logic [SLICE_W-1:0] s_s;

            if (j == 0) begin : g_cin
                assign cin_s = cin_stage;
            end else begin : g_cin
                assign cin_s = g_slice[j-1].gg_s | (g_slice[j-1].pg_s & g_slice[j-1].cin_s);
            end

            cla_slice4 u_slice (
                .a   (a_src[BIT +: SLICE_W]),
                .b   (b_src[BIT +: SLICE_W]),
                .cin (cin_s),
                .s   (s_s),
                .gg  (gg_s),
                .pg  (pg_s),
                .c3  (c3_s)
            );

            assign s_stage[j*SLICE_W +: SLICE_W] = s_s;

            if (j != SLICES_PER_STAGE - 1) begin : g_c3_sink
                logic unused_c3;
                assign unused_c3 = c3_s;
            end
        end

        assign cout   = g_slice[SLICES_PER_STAGE-1].gg_s
                      | (g_slice[SLICES_PER_STAGE-1].pg_s & g_slice[SLICES_PER_STAGE-1].cin_s);
        assign c3_top = g_slice[SLICES_PER_STAGE-1].c3_s;

        always_comb begin
            word_d                 = a_src;
            word_d[LO +: STAGE_W]  = s_stage;
        end

        // A stage moves when it or anything downstream has room, or the sink pops.
        assign vld[k] = vld_q;
        assign adv[k] = out_ready | ~(&vld[NUM_STAGES-1:k]);

        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                vld_q  <= 1'b0;
                word_q <= '0;
                b_q    <= '0;
                cy_q   <= 1'b0;
                ovf_q  <= 1'b0;
            end else if (adv[k]) begin
                vld_q <= up_vld;
                if (up_vld) begin
                    word_q <= word_d;
                    b_q    <= b_src;
                    cy_q   <= cout;
                    ovf_q  <= c3_top ^ cout;
                end
            end
        end

        if (k != NUM_STAGES - 1) begin : g_ovf_sink
            logic unused_ovf;
            assign unused_ovf = ovf_q;
        end else begin : g_b_sink
            logic unused_b;
            assign unused_b = ^b_q;
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = vld[NUM_STAGES-1];
    assign sum       = g_stage[NUM_STAGES-1].word_q;
    assign co        = g_stage[NUM_STAGES-1].cy_q;
    assign ovf       = g_stage[NUM_STAGES-1].ovf_q;

endmodule
